// File: rtl/oam_dma_controller.sv
// NES sprite DMA sequencer and CPU/DMA bus arbiter. Copies page XX00-XXFF to the OAM data port.
// Optional OAM_DMA_ALIGN_EN builds the odd-cycle ALIGN state and the cycle_odd parity flop.
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clock0,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_read_not_write,
    output logic        cpu_ready,
    input  logic [7:0]  bus_data_in,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_data_out,
    output logic        bus_read_not_write,
    output logic        dma_active
);

`ifdef OAM_DMA_ALIGN_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;
`endif

    state_t     state, state_nx;
    logic [7:0] page;
    logic [7:0] index;
    logic [7:0] latch;
    logic       trigger;
    logic       last_byte;

    assign trigger   = (state == IDLE) && !cpu_read_not_write && (cpu_address == DMA_REG_ADDR);
    assign last_byte = (index == 8'hFF);

`ifdef OAM_DMA_ALIGN_EN
    logic cycle_odd;

    // Free-running parity of the CPU cycle; DMA reads must land on even cycles.
    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) cycle_odd <= 1'b0;
        else       cycle_odd <= ~cycle_odd;
    end
`endif

    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (trigger) state_nx = HALT;
            // Halt takes effect only on a read cycle; in-flight CPU writes finish first.
            HALT: begin
                if (cpu_read_not_write) begin
`ifdef OAM_DMA_ALIGN_EN
                    state_nx = cycle_odd ? ALIGN : READ;
`else
                    state_nx = READ;
`endif
                end
            end
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: state_nx = READ;
`endif
            READ:  state_nx = WRITE;
            WRITE: state_nx = last_byte ? IDLE : READ;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            page  <= 8'h00;
            index <= 8'h00;
            latch <= 8'h00;
        end else begin
            if (trigger) begin
                page  <= cpu_data_out;
                index <= 8'h00;
            end
            if (state == READ) latch <= bus_data_in;
            if (state == WRITE && !last_byte) index <= index + 8'h01;
        end
    end

    always_comb begin
        cpu_ready  = (state == IDLE);
`ifdef OAM_DMA_ALIGN_EN
        dma_active = (state == ALIGN) || (state == READ) || (state == WRITE);
`else
        dma_active = (state == READ) || (state == WRITE);
`endif
    end

    always_comb begin
        bus_address        = cpu_address;
        bus_data_out       = cpu_data_out;
        bus_read_not_write = cpu_read_not_write;
        case (state)
`ifdef OAM_DMA_ALIGN_EN
            ALIGN: begin
                bus_address        = OAM_DATA_ADDR;
                bus_data_out       = latch;
                bus_read_not_write = 1'b1;
            end
`endif
            READ: begin
                bus_address        = {page, index};
                bus_data_out       = latch;
                bus_read_not_write = 1'b1;
            end
            WRITE: begin
                bus_address        = OAM_DATA_ADDR;
                bus_data_out       = latch;
                bus_read_not_write = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
- Sequences the NES sprite DMA and arbitrates the single system bus between the 6502 core and the DMA engine.
- A CPU write to the DMA register latches a source page, then halts the CPU through its ready input on its next read cycle.
- It then copies 256 bytes from page XX00-XXFF to the OAM data port, then releases the bus.
- It sits between the 6502 core's bus pins and the system address/data decode.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address written on every DMA write cycle.

Ports:
- clock0  input  1  system clock; one edge = one CPU cycle.
- reset  input  1  asynchronous, active-high reset.
- cpu_address  input  16  address from the 6502 core.
- cpu_data_out  input  8  write data from the core.
- cpu_read_not_write  input  1  core bus direction; 1 = read.
- cpu_ready  output  1  to core ready pin; 0 halts the core on read cycles.
- bus_data_in  input  8  read data returned from the system bus.
- bus_address  output  16  muxed system bus address.
- bus_data_out  output  8  muxed system bus write data.
- bus_read_not_write  output  1  muxed system bus direction.
- dma_active  output  1  1 while the DMA owns the bus.

Behaviour:
- Reset values: state IDLE, page=0, index=0, latch=0, cycle_odd=0, cpu_ready=1, dma_active=0. Reset mid-transfer aborts immediately; no further DMA writes occur.
- cycle_odd is a free-running flop, toggling every clock0 edge.
- Bus mux (combinational):
  - dma_active=0: bus_* = cpu_*.
  - dma_active=1: bus_* driven by the DMA; cpu_* ignored.
- cpu_ready = (state==IDLE). dma_active = state in {ALIGN, READ, WRITE}.
- IDLE:
  - If cpu_read_not_write=0 and cpu_address==DMA_REG_ADDR: page<=cpu_data_out, index<=0, go HALT.
  - A write to any other address is ignored.
- HALT:
  - CPU bus still passes through, so a CPU write in progress completes.
  - Stay while cpu_read_not_write=0.
  - On the first cycle with cpu_read_not_write=1 (the halt cycle; the CPU read is a discarded dummy): go ALIGN if cycle_odd=1, else READ.
- ALIGN: one idle DMA cycle; bus_address=OAM_DATA_ADDR, bus_read_not_write=1. Go READ.
- READ: bus_address={page,index}, bus_read_not_write=1; latch<=bus_data_in at the edge. Go WRITE.
- WRITE: bus_address=OAM_DATA_ADDR, bus_read_not_write=0, bus_data_out=latch.
  - If index==8'hFF: go IDLE.
  - Else index<=index+1, go READ.
- bus_data_out outside WRITE: passthrough when not active; latch during ALIGN/READ.
- Transfer length: 1 halt cycle + optional 1 align + 512 = 513 or 514 cycles with cpu_ready=0. cpu_ready returns to 1 on the cycle after the final WRITE.
- Index wrap: the address never leaves the page; {page,8'hFF} is the last source byte.
- A write to DMA_REG_ADDR outside IDLE is ignored, since the CPU is halted and cannot issue it.
- Page 8'h20 (source = OAM_DATA_ADDR region) is legal; no special handling.

Optional Feature:
- Macro: OAM_DMA_ALIGN_EN.
  - Defined: ALIGN state and cycle_odd exist as above; the transfer is 513 or 514 cycles depending on parity.
  - Undefined: ALIGN and cycle_odd are not built; HALT always goes to READ; the transfer is always 513 cycles.

Test Plan:
- Basic copy: CPU writes 8'h02 to 16'h4014, then issues a read; memory 0200-02FF holds i^8'h5A -> 256 writes to 16'h2004 with data 8'h5A, 8'h5B, ... in index order; cpu_ready low for exactly 513/514 cycles per parity.
- Parity: trigger the halt cycle with cycle_odd=1 -> one ALIGN cycle observed, 514 total. With cycle_odd=0 -> 513. With OAM_DMA_ALIGN_EN undefined -> 513 in both cases.
- Write stall: CPU issues 2 further write cycles after the trigger -> both pass to the bus unmodified, and the DMA starts only after the following read.
- Non-trigger writes: CPU writes 16'h4015 and 16'h4013 -> state stays IDLE, cpu_ready=1, dma_active=0.
- Reset mid-transfer: assert reset at index 8'h40 -> cpu_ready=1 and dma_active=0 immediately (asynchronously); no write to 16'h2004 after the reset edge. A new trigger then restarts at index 0.
- Passthrough: with the DMA idle, random CPU addresses, data and direction -> bus_* equal cpu_* every cycle.
